// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester block-RAM arbiter.
// Requester IDs double as the round-robin priority value and the read-response tag.
// STAT_W sets the width of the optional statistics counters.
package bram_arb_pkg;

  localparam logic REQ_LOAD = 1'b0;  // load / DMA path
  localparam logic REQ_CONV = 1'b1;  // conv engine
  localparam int   STAT_W   = 16;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants one requester per cycle, fair under contention.
// Latency: grant is combinational from req and the registered priority.
// Backpressure: a requester that is not granted simply keeps req high and wins next cycle.
// Ports: clk, rst (sync active-high), req[1:0] in; gnt[1:0] (one-hot or zero), prio out.
module rr_arb2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       prio
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (prio_q == REQ_CONV) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    // The winner hands priority to the other side; idle cycles keep it.
    if (gnt[0]) begin
      prio_d = REQ_CONV;
    end else if (gnt[1]) begin
      prio_d = REQ_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= REQ_LOAD;
    end else begin
      prio_q <= prio_d;
    end
  end

  assign prio = prio_q;

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM between the load path (0) and conv engine (1).
// Latency: request to RAM port is combinational; read data returns one cycle after the grant.
// Backpressure: reqN_ready low holds the requester; responses have none and must be accepted.
// Ports: req0_*/req1_* request channels, rsp0/1_valid + shared rsp_rdata, bram_* RAM port.
// Optional: define BRAM_ARB_STATS_EN to add stat_grant0/stat_grant1/stat_conflict counters.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int W_DATA = 32,
  parameter int W_WORD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [W_WORD-1:0] req0_addr,
  input  logic [W_DATA-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [W_WORD-1:0] req1_addr,
  input  logic [W_DATA-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              bram_en,
  output logic              bram_we,
  output logic [W_WORD-1:0] bram_addr,
  output logic [W_DATA-1:0] bram_din,
  input  logic [W_DATA-1:0] bram_dout
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  logic [1:0] gnt;
  logic       arb_prio;
  logic       any_gnt;
  logic       gnt_id;
  logic       sel_conv;
  logic       sel_we;
  logic       rsp_vld_q, rsp_vld_d;
  logic       rsp_id_q, rsp_id_d;

  rr_arb2 u_rr_arb2 (
    .clk  (clk),
    .rst  (rst),
    .req  ({req1_valid, req0_valid}),
    .gnt  (gnt),
    .prio (arb_prio)
  );

  // Under contention the winner is whoever holds priority; otherwise the lone requester.
  assign any_gnt  = |gnt;
  assign gnt_id   = (req0_valid && req1_valid) ? arb_prio : (req1_valid ? REQ_CONV : REQ_LOAD);
  // Without a grant the address/data mux rests on requester 0.
  assign sel_conv = any_gnt && (gnt_id == REQ_CONV);
  assign sel_we   = sel_conv ? req1_we : req0_we;

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign bram_en   = any_gnt;
  assign bram_we   = any_gnt && sel_we;
  assign bram_addr = sel_conv ? req1_addr  : req0_addr;
  assign bram_din  = sel_conv ? req1_wdata : req0_wdata;

  // Tag each granted read so the returning word goes to its issuer only.
  always_comb begin
    rsp_vld_d = any_gnt && !sel_we;
    rsp_id_d  = gnt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= REQ_LOAD;
    end else begin
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

  assign rsp0_valid = rsp_vld_q && (rsp_id_q == REQ_LOAD);
  assign rsp1_valid = rsp_vld_q && (rsp_id_q == REQ_CONV);
  assign rsp_rdata  = bram_dout;

`ifdef BRAM_ARB_STATS_EN
  logic [STAT_W-1:0] stat_grant0_q, stat_grant1_q, stat_conflict_q;

  // Counters wrap naturally at 2^STAT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (gnt[0]) stat_grant0_q <= stat_grant0_q + STAT_W'(1);
      if (gnt[1]) stat_grant1_q <= stat_grant1_q + STAT_W'(1);
      if (req0_valid && req1_valid) stat_conflict_q <= stat_conflict_q + STAT_W'(1);
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural 1-cycle-latency BRAM.
// Expected read responses are queued when a read grant is expected and popped one cycle later.
// Inputs change 1 time unit after posedge; outputs sampled at posedge+3 and at negedge.
module tb_bram_arbiter;

  localparam int W_DATA = 32;
  localparam int W_WORD = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req0_we = 1'b0;
  logic [W_WORD-1:0] req0_addr = '0;
  logic [W_DATA-1:0] req0_wdata = '0;
  logic              req1_valid = 1'b0, req1_we = 1'b0;
  logic [W_WORD-1:0] req1_addr = '0;
  logic [W_DATA-1:0] req1_wdata = '0;
  logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [W_DATA-1:0] rsp_rdata;
  logic              bram_en, bram_we;
  logic [W_WORD-1:0] bram_addr;
  logic [W_DATA-1:0] bram_din;
  logic [W_DATA-1:0] bram_dout;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0]       stat_grant0, stat_grant1, stat_conflict;
`endif

  int checks   = 0;
  int failures = 0;

  bram_arbiter #(.W_DATA(W_DATA), .W_WORD(W_WORD)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
`ifdef BRAM_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write wins, dout holds on write and idle cycles.
  logic [W_DATA-1:0] ram [16];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) ram[bram_addr] <= bram_din;
      else         bram_dout <= ram[bram_addr];
    end
  end

  // Reference model state.
  logic [W_DATA-1:0] ref_mem [16];
  logic              m_prio = 1'b0;
  logic [1:0]        exp_g;

  typedef struct packed {
    logic              vld;
    logic              id;
    logic [W_DATA-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Response scoreboard: the entry pushed in the previous cycle is due now.
  always @(negedge clk) begin
    if (exp_q.size() >= 2) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({rsp1_valid, rsp0_valid} !== (mon_e.vld ? (mon_e.id ? 2'b10 : 2'b01) : 2'b00)) begin
        failures++;
        $display("FAIL rsp_valid t=%0t got=%b%b exp vld=%b id=%b", $time,
                 rsp1_valid, rsp0_valid, mon_e.vld, mon_e.id);
      end
      if (mon_e.vld) begin
        checks++;
        if (rsp_rdata !== mon_e.data) begin
          failures++;
          $display("FAIL rsp_rdata t=%0t got=%h exp=%h", $time, rsp_rdata, mon_e.data);
        end
      end
    end
  end

  // Apply one cycle of stimulus and record what the spec says should happen.
  task automatic drive(input logic r,
                       input logic v0, input logic we0, input logic [3:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [3:0] a1, input logic [31:0] d1);
    logic id, we;
    logic [3:0] a;
    logic [31:0] d;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
    if (r)             exp_g = 2'b00;
    else if (v0 && v1) exp_g = m_prio ? 2'b10 : 2'b01;
    else               exp_g = {v1, v0};
    e = '0;
    if (exp_g != 2'b00) begin
      id = exp_g[1];
      we = id ? we1 : we0;
      a  = id ? a1 : a0;
      d  = id ? d1 : d0;
      if (we) ref_mem[a] = d;
      else begin
        e.vld = 1'b1; e.id = id; e.data = ref_mem[a];
      end
      m_prio = ~id;
    end
    if (r) m_prio = 1'b0;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic idle(input logic r);
    drive(r, 0, 0, 4'd0, 32'd0, 0, 0, 4'd0, 32'd0);
  endtask

  task automatic test_reset();
    idle(1);
    idle(1);
    checks++;
    if ({req1_ready, req0_ready, bram_en, bram_we, rsp1_valid, rsp0_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%b%b en=%b we=%b rsp=%b%b exp all 0",
               req1_ready, req0_ready, bram_en, bram_we, rsp1_valid, rsp0_valid);
    end
    // Requests during reset must not be granted.
    drive(1, 1, 0, 4'd1, 32'd0, 1, 0, 4'd2, 32'd0);
    checks++;
    if ({req1_ready, req0_ready, bram_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_no_grant got rdy=%b%b en=%b exp 000", req1_ready, req0_ready, bram_en);
    end
`ifdef BRAM_ARB_STATS_EN
    checks++;
    if ({stat_grant0, stat_grant1, stat_conflict} !== 48'd0) begin
      failures++;
      $display("FAIL reset_stats got %0d %0d %0d exp 0 0 0", stat_grant0, stat_grant1, stat_conflict);
    end
`endif
  endtask

  task automatic test_write_idle();
    idle(0);
    drive(0, 1, 1, 4'd3, 32'hDEADBEEF, 0, 0, 4'd0, 32'd0);
    checks++;
    if ({req0_ready, req1_ready, bram_en, bram_we} !== 4'b1011 || bram_addr !== 4'd3 ||
        bram_din !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_drive got rdy0=%b rdy1=%b en=%b we=%b addr=%0d din=%h exp 1 0 1 1 3 deadbeef",
               req0_ready, req1_ready, bram_en, bram_we, bram_addr, bram_din);
    end
    idle(0);
    checks++;
    if ({rsp0_valid, rsp1_valid, bram_en} !== 3'b000) begin
      failures++;
      $display("FAIL write_no_rsp got rsp0=%b rsp1=%b en=%b exp 000", rsp0_valid, rsp1_valid, bram_en);
    end
  endtask

  task automatic test_read_latency();
    drive(0, 0, 0, 4'd0, 32'd0, 1, 0, 4'd3, 32'd0);
    checks++;
    if ({req1_ready, req0_ready, bram_en, bram_we} !== 4'b1010 || bram_addr !== 4'd3) begin
      failures++;
      $display("FAIL read_grant got rdy1=%b rdy0=%b en=%b we=%b addr=%0d exp 1 0 1 0 3",
               req1_ready, req0_ready, bram_en, bram_we, bram_addr);
    end
    idle(0);
    checks++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL read_latency got rsp1=%b rsp0=%b data=%h exp 1 0 deadbeef",
               rsp1_valid, rsp0_valid, rsp_rdata);
    end
  endtask

  task automatic test_contention();
    idle(1);
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 4'd1, 32'd0, 1, 0, 4'd2, 32'd0);
      checks++;
      if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL contention_grant cycle=%0d got=%b%b exp=%b", i, req1_ready, req0_ready,
                 (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    idle(0);
  endtask

  task automatic test_write_then_read();
    drive(0, 1, 1, 4'd5, 32'h12345678, 0, 0, 4'd0, 32'd0);
    drive(0, 0, 0, 4'd0, 32'd0, 1, 0, 4'd5, 32'd0);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL wtr_grant got rdy1=%b exp 1", req1_ready);
    end
    idle(0);
    checks++;
    if (rsp1_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL wtr_data got rsp1=%b data=%h exp 1 12345678", rsp1_valid, rsp_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1, 0, 4'd1, 32'd0, 0, 0, 4'd0, 32'd0);
    drive(1, 1, 0, 4'd1, 32'd0, 0, 0, 4'd0, 32'd0);
    checks++;
    if (req0_ready !== 1'b0 || bram_en !== 1'b0) begin
      failures++;
      $display("FAIL midreset_grant got rdy0=%b en=%b exp 0 0", req0_ready, bram_en);
    end
    drive(0, 1, 0, 4'd1, 32'd0, 1, 0, 4'd2, 32'd0);
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_rsp got rsp0=%b rsp1=%b exp 0 0", rsp0_valid, rsp1_valid);
    end
    checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      failures++;
      $display("FAIL midreset_first got=%b%b exp=01", req1_ready, req0_ready);
    end
    idle(0);
  endtask

  task automatic test_back_to_back();
    // Mixed reads and writes from both sides with gaps, checked by the scoreboard.
    for (int i = 0; i < 40; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), $urandom);
      checks++;
      if ({req1_ready, req0_ready} !== exp_g || bram_en !== (exp_g != 2'b00)) begin
        failures++;
        $display("FAIL b2b_grant cycle=%0d got=%b%b en=%b exp=%b", i, req1_ready, req0_ready,
                 bram_en, exp_g);
      end
    end
    idle(0);
  endtask

`ifdef BRAM_ARB_STATS_EN
  task automatic test_stats();
    idle(1);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 4'd1, 32'd0, 1, 0, 4'd2, 32'd0);
    idle(0);
    checks++;
    if (stat_conflict !== 16'd10 || stat_grant0 !== 16'd5 || stat_grant1 !== 16'd5) begin
      failures++;
      $display("FAIL stats_count got c=%0d g0=%0d g1=%0d exp 10 5 5",
               stat_conflict, stat_grant0, stat_grant1);
    end
    idle(1);
    idle(0);
    checks++;
    if ({stat_conflict, stat_grant0, stat_grant1} !== 48'd0) begin
      failures++;
      $display("FAIL stats_clear got c=%0d g0=%0d g1=%0d exp 0 0 0",
               stat_conflict, stat_grant0, stat_grant1);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 32'hA000_0000 | 32'(i);
      ref_mem[i] = 32'hA000_0000 | 32'(i);
    end
    exp_q.push_back('0);
    test_reset();
    test_write_idle();
    test_read_latency();
    test_contention();
    test_write_then_read();
    test_reset_mid_read();
    test_back_to_back();
`ifdef BRAM_ARB_STATS_EN
    test_stats();
`endif
    idle(0);
    idle(0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-requester arbiter that shares one single-port block RAM between the CNN accelerator's load/DMA path (requester 0) and the conv engine (requester 1).
- The RAM has one-cycle read latency, word addressing and write-over-read priority.
- The arbiter grants one access per cycle using round-robin priority and drives the RAM port directly.
- It returns read data to the requester that issued the read, one cycle after the grant.

Parameters:
- W_DATA, 32, data word width; must match the RAM.
- W_WORD, 4, address width in words; must match the RAM.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 access request.
- req0_we  in  1  requester 0: 1 = write, 0 = read.
- req0_addr  in  W_WORD  requester 0 word address.
- req0_wdata  in  W_DATA  requester 0 write data.
- req0_ready  out  1  requester 0 granted this cycle.
- rsp0_valid  out  1  read data for requester 0 is on rsp_rdata.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid: same as above, for requester 1.
- rsp_rdata  out  W_DATA  shared read-data bus; equals bram_dout.
- bram_en  out  1  RAM enable.
- bram_we  out  1  RAM write enable.
- bram_addr  out  W_WORD  RAM address.
- bram_din  out  W_DATA  RAM write data.
- bram_dout  in  W_DATA  RAM read data.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - While rst=1: req0_ready=0, req1_ready=0, bram_en=0, bram_we=0.
  - On the clock edge with rst=1: rsp0_valid<=0, rsp1_valid<=0, prio<=0 (requester 0 favoured).
- Grant (combinational from the current inputs and registered prio):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant prio.
  - Neither valid: no grant.
- Handshake:
  - reqN_ready equals grantN.
  - A transfer occurs when reqN_valid and reqN_ready are both 1.
  - A requester holds valid, we, addr and wdata stable until it sees ready.
  - valid must not depend on ready.
- RAM drive:
  - On a grant: bram_en=1; bram_we, bram_addr and bram_din are muxed from the granted requester.
  - With no grant: bram_en=0, bram_we=0; bram_addr and bram_din are don't-care, held at requester 0's values.
- Priority update:
  - When requester i is granted, prio<=~i on the next edge.
  - With no grant, prio holds.
  - No requester waits more than 1 cycle while the other is continuously requesting.
- Read response:
  - A read granted in cycle T asserts rspN_valid=1 in cycle T+1 for that requester only.
  - rsp_rdata=bram_dout in that cycle.
  - Writes never raise rspN_valid; the RAM holds its dout on write cycles.
  - rsp0_valid and rsp1_valid are never both 1.
  - There is no back-pressure on responses: a requester must accept rspN_valid unconditionally.
- Ordering:
  - A write granted at T followed by a read of the same address granted at T+1 returns the new data at T+2, for either requester.
  - Back-to-back reads at T and T+1 give responses at T+1 and T+2.
  - Throughput is 1 access per cycle.
- Reset mid-operation:
  - A read granted in the cycle rst rises produces no response; rsp*_valid=0 the next cycle.
  - The RAM contents are not affected by rst.
- rst deasserted with both requesters valid: requester 0 is granted first.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- Defined: adds three outputs, each wrapping modulo 2^16 and cleared by rst:
  - stat_grant0 [15:0]: count of requester 0 grants.
  - stat_grant1 [15:0]: count of requester 1 grants.
  - stat_conflict [15:0]: count of cycles with both reqN_valid=1 outside reset.
- Not defined: these ports and counters do not exist; arbitration behaviour is identical.

Decomposition:
- Package bram_arb_pkg holds:
  - REQ_LOAD=1'b0 and REQ_CONV=1'b1 requester IDs, used for prio and the response tag.
  - STAT_W=16.
- One sub-module, rr_arb2: a 2-way round-robin arbiter.
  - Inputs: clk, rst, req[1:0].
  - Outputs: gnt[1:0] (one-hot or zero), plus the prio register.
- bram_arbiter holds the request/RAM muxing, the response tag register and the optional counters.

Test Plan:
1. Reset release, idle: after 2 cycles of rst=1, all outputs 0. Then req0 writes addr 3, data 0xDEADBEEF -> req0_ready=1, bram_en=1, bram_we=1, bram_addr=3 in the same cycle; no rsp0_valid follows.
2. Read response latency: after test 1, req1 reads addr 3 at T -> rsp1_valid=1 and rsp_rdata=0xDEADBEEF at T+1; rsp0_valid=0.
3. Contention fairness: both requesters hold valid reads (addr 1 and addr 2) for 6 cycles from reset -> grants alternate 0,1,0,1,0,1. Responses alternate rsp0/rsp1 one cycle later with the matching data.
4. Write-then-read: req0 writes addr 5 = 0x12345678 at T, req1 reads addr 5 at T+1 -> rsp1_valid at T+2 with 0x12345678.
5. Reset mid-read: req0 read granted in the cycle rst rises -> rsp0_valid=0 next cycle. After release, both valid -> requester 0 is granted first.
6. BRAM_ARB_STATS_EN: 10 contention cycles -> stat_conflict=10, stat_grant0=5, stat_grant1=5. Then rst -> all counters 0.
